// File: rtl/rterm_cal_pkg.sv
// Shared types, mode encodings and the code-to-thermometer helper for the
// termination calibration controller.
`timescale 1ns/1ps
package rterm_cal_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSgSet,
    StSgWait,
    StSgEval,
    StLvSet,
    StLvWait,
    StLvEval,
    StDone
  } cal_state_e;

  localparam logic [1:0] ModeIdle = 2'b00;
  localparam logic [1:0] ModeSg   = 2'b01;
  localparam logic [1:0] ModeLv   = 2'b10;

  // Output bit k-1 carries thermometer bit k, which is set iff code >= k.
  function automatic logic [14:0] code_to_therm(input logic [3:0] code);
    logic [14:0] therm;
    for (int k = 1; k <= 15; k++) begin
      therm[k-1] = ({1'b0, code} >= 5'(k));
    end
    return therm;
  endfunction

endpackage

// File: rtl/rterm_cal_sync.sv
// Multi-flop synchronizer for the asynchronous comparator results.
`timescale 1ns/1ps
module rterm_cal_sync #(
  parameter int unsigned Width  = 2,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Stages); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(Stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/rterm_cal_ctrl.sv
// Termination calibration controller: 4-bit successive-approximation search on
// the SGIO branch then the LVDS branch, holding the committed trim codes.
`timescale 1ns/1ps
module rterm_cal_ctrl
  import rterm_cal_pkg::*;
#(
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned SyncStages   = 2,
  parameter logic [3:0]  SgResetCode  = 4'd8,
  parameter logic [3:0]  LvResetCode  = 4'd8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [1:0]  result_i,
  output logic [14:0] d_iosg_o,
  output logic [3:0]  d_lvds_o,
  output logic [1:0]  mode_o,
  output logic [3:0]  sg_code_o,
  output logic [3:0]  lv_code_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  sat_o
);

  localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);

  cal_state_e      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      work_q, work_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      sg_code_q, sg_code_d;
  logic [3:0]      lv_code_q, lv_code_d;
  logic [1:0]      sat_q, sat_d;
  logic [1:0]      result_sync;
  logic [3:0]      bit_mask;
  logic [3:0]      eval_code;
  logic            eval_res;

  rterm_cal_sync #(
    .Width  (2),
    .Stages (SyncStages)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (result_i),
    .q_o    (result_sync)
  );

  assign bit_mask  = 4'b0001 << idx_q;
  assign eval_res  = (state_q == StLvEval) ? result_sync[1] : result_sync[0];
  // A high comparator means the trial code overshoots, so the trial bit is dropped.
  assign eval_code = eval_res ? (work_q & ~bit_mask) : work_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    sg_code_d = sg_code_q;
    lv_code_d = lv_code_q;
    sat_d     = sat_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StSgSet;
          idx_d   = 2'd3;
          work_d  = '0;
          sat_d   = '0;
        end
      end
      StSgSet, StLvSet: begin
        work_d  = work_q | bit_mask;
        cnt_d   = CntLoad;
        state_d = (state_q == StSgSet) ? StSgWait : StLvWait;
      end
      StSgWait, StLvWait: begin
        if (cnt_q == '0) begin
          state_d = (state_q == StSgWait) ? StSgEval : StLvEval;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSgEval, StLvEval: begin
        work_d = eval_code;
        if (idx_q != 2'd0) begin
          idx_d   = idx_q - 2'd1;
          state_d = (state_q == StSgEval) ? StSgSet : StLvSet;
        end else if (state_q == StSgEval) begin
          sg_code_d = eval_code;
          sat_d[0]  = (eval_code == 4'd0) || (eval_code == 4'd15);
          idx_d     = 2'd3;
          work_d    = '0;
          state_d   = StLvSet;
        end else begin
          lv_code_d = eval_code;
          sat_d[1]  = (eval_code == 4'd0) || (eval_code == 4'd15);
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides any transition, including a start or a final commit.
    if (abort_i) begin
      state_d   = StIdle;
      idx_d     = idx_q;
      work_d    = '0;
      cnt_d     = cnt_q;
      sg_code_d = sg_code_q;
      lv_code_d = lv_code_q;
      sat_d     = sat_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      sg_code_q <= SgResetCode;
      lv_code_q <= LvResetCode;
      sat_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      sg_code_q <= sg_code_d;
      lv_code_q <= lv_code_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    mode_o   = ModeIdle;
    d_iosg_o = code_to_therm(sg_code_q);
    d_lvds_o = lv_code_q;
    unique case (state_q)
      StSgSet, StSgWait, StSgEval: begin
        mode_o   = ModeSg;
        d_iosg_o = code_to_therm(work_q);
      end
      StLvSet, StLvWait, StLvEval: begin
        mode_o   = ModeLv;
        d_lvds_o = work_q;
      end
      default: begin
        mode_o = ModeIdle;
      end
    endcase
  end

  assign sg_code_o = sg_code_q;
  assign lv_code_o = lv_code_q;
  assign sat_o     = sat_q;
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_rterm_cal_ctrl.sv
// Directed bench for rterm_cal_ctrl with a behavioural pad-cell model and a
// scoreboard of expected calibration results.
`timescale 1ns/1ps
module tb_rterm_cal_ctrl;

  localparam int Settle = 4;
  localparam int Lat    = 8 * (Settle + 2) + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [1:0]  result;
  logic [1:0]  ovr;
  int          sel;
  logic [14:0] d_iosg;
  logic [3:0]  d_lvds;
  logic [1:0]  mode;
  logic [3:0]  sg_code;
  logic [3:0]  lv_code;
  logic        busy;
  logic        done;
  logic [1:0]  sat;
  logic        r0;
  logic        r1;

  typedef struct {
    int         lat;
    logic [3:0] sg;
    logic [3:0] lv;
    logic [1:0] sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rterm_cal_ctrl #(
    .SettleCycles (Settle),
    .SyncStages   (2),
    .SgResetCode  (4'd8),
    .LvResetCode  (4'd8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .abort_i   (abort),
    .result_i  (result),
    .d_iosg_o  (d_iosg),
    .d_lvds_o  (d_lvds),
    .mode_o    (mode),
    .sg_code_o (sg_code),
    .lv_code_o (lv_code),
    .busy_o    (busy),
    .done_o    (done),
    .sat_o     (sat)
  );

  always_comb begin
    r0 = mode[0] && ((20 + 5000 / (17 + $countones(d_iosg))) < 200);
    r1 = mode[1] && !mode[0] && ((-10 + 5000 / (17 + int'(d_lvds))) < 200);
  end

  assign result = (sel == 0) ? {r1, r0} : (sel == 1) ? 2'b10 : ovr;

  function automatic logic [14:0] therm_of(input logic [3:0] c);
    int v;
    v = (1 << c) - 1;
    return v[14:0];
  endfunction

  function automatic logic [1:0] sat_of(input logic [3:0] sg, input logic [3:0] lv);
    return {(lv == 4'd0 || lv == 4'd15), (sg == 4'd0 || sg == 4'd15)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 ns into cycle 1 (the first cycle after START was sampled).
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int restart_at, output int lat, output int sg_cyc,
                           output int lv_cyc);
    lat    = 1;
    sg_cyc = 0;
    lv_cyc = 0;
    while (!done && lat < 200) begin
      if (mode == 2'b01) sg_cyc++;
      if (mode == 2'b10) lv_cyc++;
      start = (lat == restart_at);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int lat);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_sg_code"}, 32'(sg_code), 32'(e.sg));
      chk({tag, "_lv_code"}, 32'(lv_code), 32'(e.lv));
      chk({tag, "_sat"}, 32'(sat), 32'(e.sat));
      chk({tag, "_d_iosg"}, 32'(d_iosg), 32'(therm_of(e.sg)));
      chk({tag, "_d_lvds"}, 32'(d_lvds), 32'(e.lv));
      @(posedge clk);
      #1;
      chk({tag, "_idle_after"}, 32'({busy, done}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, sg_cyc, lv_cyc, dones;
    logic [7:0] vbits;
    logic [3:0] sg_e, lv_e;
    exp_t e;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ovr   = 2'b00;
    sel   = 0;
    #23 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset and idle values.
    chk("rst_sg_code", 32'(sg_code), 32'd8);
    chk("rst_lv_code", 32'(lv_code), 32'd8);
    chk("rst_d_iosg", 32'(d_iosg), 32'h00FF);
    chk("rst_d_lvds", 32'(d_lvds), 32'h8);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_busy_done_sat", 32'({busy, done, sat}), 32'd0);

    // Nominal calibration.
    e = '{lat: Lat, sg: 4'd10, lv: 4'd6, sat: 2'b00};
    sb.push_back(e);
    pulse_start();
    chk("nom_busy_c1", 32'(busy), 32'd1);
    wait_done(0, lat, sg_cyc, lv_cyc);
    chk("nom_sg_mode_cycles", 32'(sg_cyc), 32'd24);
    chk("nom_lv_mode_cycles", 32'(lv_cyc), 32'd24);
    chk("nom_mode_in_done", 32'(mode), 32'd0);
    check_result("nom", lat);

    // Abort ten cycles after start.
    pulse_start();
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    chk("abt_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_mode", 32'(mode), 32'd0);
    chk("abt_codes", 32'({sg_code, lv_code}), 32'h0A6);
    chk("abt_d_iosg", 32'(d_iosg), 32'h03FF);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    chk("abt_no_done", 32'(dones), 32'd0);

    // Start and abort together in idle.
    @(posedge clk);
    #1 start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);

    // Start re-pulsed mid-LVDS phase is ignored.
    e = '{lat: Lat, sg: 4'd10, lv: 4'd6, sat: 2'b00};
    sb.push_back(e);
    pulse_start();
    wait_done(30, lat, sg_cyc, lv_cyc);
    check_result("restart", lat);

    // Stuck comparator outputs drive both codes to the rails.
    sel = 1;
    e = '{lat: Lat, sg: 4'd15, lv: 4'd0, sat: 2'b11};
    sb.push_back(e);
    pulse_start();
    wait_done(0, lat, sg_cyc, lv_cyc);
    check_result("stuck", lat);

    // Forced per-bit comparator values with an asynchronous flip one cycle
    // before each evaluation; the flip must be too late to influence it.
    sel = 2;
    for (int r = 0; r < 2; r++) begin
      vbits = (r == 0) ? 8'b0110_1001 : 8'($urandom_range(0, 255));
      for (int j = 0; j < 4; j++) begin
        sg_e[3-j] = ~vbits[j];
        lv_e[3-j] = ~vbits[4+j];
      end
      e = '{lat: Lat, sg: sg_e, lv: lv_e, sat: sat_of(sg_e, lv_e)};
      sb.push_back(e);
      pulse_start();
      for (int j = 0; j < 8; j++) begin
        repeat (3) @(posedge clk);
        #1 ovr = {2{vbits[j]}};
        @(posedge clk);
        #($urandom_range(1, 9)) ovr = {2{~vbits[j]}};
        @(posedge clk);
        @(posedge clk);
        #1;
      end
      check_result("async", done ? Lat : 0);
    end

    // Asynchronous reset in the middle of a run.
    sel = 0;
    pulse_start();
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_codes", 32'({sg_code, lv_code}), 32'h088);
    chk("mid_rst_d_iosg", 32'(d_iosg), 32'h00FF);
    chk("mid_rst_d_lvds", 32'(d_lvds), 32'h8);
    chk("mid_rst_ctrl", 32'({mode, busy, done, sat}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(busy), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rterm_cal_ctrl.md
Name: rterm_cal_ctrl

Overview:
- Digital calibration controller on the core side of the termination-calibration pad cell.
- Drives the cell's SGIO trim code (15-bit thermometer), LVDS trim code (4-bit binary) and 2-bit mode.
- Runs a 4-bit successive-approximation search per branch against the cell's asynchronous comparator outputs.
- Holds the final codes for distribution to the IO ring; sits in the IO-ring control block, one instance per calibration pad.

Parameters:
- SETTLE_CYCLES, 8, clocks to wait after changing a code before sampling the comparator; must be >= SYNC_STAGES+1.
- SYNC_STAGES, 2, depth of the comparator-result synchronizer; minimum 2.
- SG_RESET_CODE, 4'd8, SGIO code driven and held after reset; range 0..15.
- LV_RESET_CODE, 4'd8, LVDS code driven and held after reset; range 0..15.

Ports:
- CLK_I  input  1  core clock.
- RST_NI  input  1  asynchronous active-low reset.
- START_I  input  1  single-cycle pulse that starts a full calibration; ignored while BUSY_O=1.
- ABORT_I  input  1  returns to IDLE next cycle; stored codes are unchanged.
- RESULT_I  input  2  comparator outputs from the cell; asynchronous to CLK_I.
- D_IOSG_O  output  15  thermometer trim to the cell, bits [15:1]; bit k set iff code >= k.
- D_LVDS_O  output  4  binary trim to the cell.
- MODE_O  output  2  cell mode: 00 idle, 01 SGIO compare, 10 LVDS compare.
- SG_CODE_O  output  4  calibrated SGIO code, binary.
- LV_CODE_O  output  4  calibrated LVDS code.
- BUSY_O  output  1  high from the cycle after START_I until DONE.
- DONE_O  output  1  one-cycle pulse when calibration completes.
- SAT_O  output  2  [0] SGIO final code 0 or 15; [1] same check for LVDS. Cleared at start.

Behaviour:
- Reset values: all outputs 0 except SG_CODE_O=SG_RESET_CODE and LV_CODE_O=LV_RESET_CODE. D_IOSG_O and D_LVDS_O reflect those codes.
- Synchronizer: RESULT_I passes through SYNC_STAGES flops. Only the synchronized value is used.
- FSM states:
  - IDLE: wait for START_I.
  - SG_SET, SG_WAIT, SG_EVAL: SGIO search, MODE_O=01.
  - LV_SET, LV_WAIT, LV_EVAL: LVDS search, MODE_O=10.
  - DONE: pulse DONE_O, then return to IDLE.
- IDLE: MODE_O=00. Trim outputs are driven from SG_CODE_O and LV_CODE_O. START_I clears SAT_O, moves to SG_SET with bit index 3 and a working code of 0.
- SET (1 cycle): set working bit[idx]. The trim output follows the working code.
- WAIT (SETTLE_CYCLES cycles): counter loads SETTLE_CYCLES-1 and counts down to 0.
- EVAL (1 cycle): sample the synced result bit (bit 0 for SGIO, bit 1 for LVDS).
  - Result 1 means resistance is below the external reference, so clear bit[idx].
  - idx>0: decrement idx, go to SET.
  - idx=0: commit the code to SG/LV_CODE_O. Set SAT_O[x] if the committed code is 0 or 15. Then go to LV_SET (after SGIO) or DONE (after LVDS).
- Each bit costs SETTLE_CYCLES+2 cycles. DONE_O rises 8*(SETTLE_CYCLES+2)+1 cycles after the START_I cycle. BUSY_O is high in every non-IDLE state, including DONE.
- The search result is the largest code whose comparator output is 0.
- During the LVDS phase, D_IOSG_O shows the already committed SG_CODE_O.
- ABORT_I has priority over every state transition. The next state is IDLE, the working code is discarded, and DONE_O is not pulsed.
- START_I and ABORT_I in the same IDLE cycle: abort wins, so the FSM stays in IDLE.
- RST_NI asserted mid-calibration: everything returns to reset values immediately and asynchronously.
- START_I while busy: ignored, with no restart.

Decomposition:
- Package rterm_cal_pkg holds:
  - the state enum;
  - MODE_IDLE, MODE_SG and MODE_LV constants;
  - a function converting a 4-bit code to the 15-bit thermometer.
- Sub-module rterm_cal_sync: a parameterized SYNC_STAGES multi-flop synchronizer, instanced for the 2-bit RESULT_I.

Test Plan:
All scenarios use SETTLE_CYCLES=4 and SYNC_STAGES=2. The bench cell model is:
- RESULT[0] = MODE[0] && (20 + 5000/(17+popcount(D_IOSG)) < 200)
- RESULT[1] = MODE[1] && !MODE[0] && (-10 + 5000/(17+D_LVDS) < 200)

1. Reset then idle -> SG_CODE_O=8, LV_CODE_O=8, D_IOSG_O=15'h00FF, D_LVDS_O=4'h8, MODE_O=00, BUSY_O=0.
2. START_I pulse with nominal model -> DONE_O exactly 49 cycles later, SG_CODE_O=10, D_IOSG_O=15'h03FF, LV_CODE_O=6, SAT_O=00. MODE_O is 01 for 24 cycles, then 10 for 24 cycles.
3. Model RESULT[0] stuck 0, RESULT[1] stuck 1 -> SG_CODE_O=15, LV_CODE_O=0, SAT_O=11.
4. ABORT_I 10 cycles after START_I -> IDLE next cycle, no DONE_O, codes remain 10/6 from the previous run, MODE_O=00.
5. START_I re-pulsed mid-LVDS phase -> ignored; completion time matches scenario 2. RST_NI mid-run -> outputs return to reset values within the same cycle.
6. RESULT_I toggled asynchronously (random phase) 1 cycle before EVAL -> decision uses the value from 2 flops earlier. Check with a bench reference model.
